irq_request_latch: RTL and testbench

- Sits directly upstream of the 4-to-2 priority encoder in the interrupt path.
- Synchronizes four asynchronous request lines, edge-detects them, and holds them in sticky pending bits. Drives the pending vector into the encoder.
- Consumes the encoder's code/valid result and presents one serviced request at a time to the consumer, using a valid/ack handshake. Clears the pending bit on acknowledge.

---
 rtl/irq_request_latch.sv | 128 ++++++++++++
 tb/tb_irq_request_latch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_latch.sv
// Interrupt request front end: synchronizes and edge-detects four request lines into sticky
// pending bits, feeds them to the priority encoder and serves one request at a time by valid/ack.
// Optional IRQ_MASK_EN adds an irq_mask input that hides pending lines from the encoder.
module irq_request_latch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    output logic [3:0] pend_out,
    input  logic [1:0] enc_id,
    input  logic       enc_valid,
    output logic       svc_valid,
    output logic [1:0] svc_id,
    input  logic       svc_ack,
    output logic [3:0] ovf,
    input  logic [3:0] ovf_clr
`ifdef IRQ_MASK_EN
    ,
    input  logic [3:0] irq_mask
`endif
);

    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned ID_W      = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    logic [NUM_LINES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_LINES-1:0] hist_q;
    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] clr;
    logic [NUM_LINES-1:0] pend_q;
    logic [NUM_LINES-1:0] ovf_q;

    state_t          state_q, state_d;
    logic [ID_W-1:0] svc_id_q, svc_id_d;
    logic            svc_valid_q, svc_valid_d;

    // Synchronizer chain plus one history stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Acknowledge clears only the line currently being presented
    always_comb begin
        clr = '0;
        if ((state_q == PRESENT) && svc_ack) begin
            clr[svc_id_q] = 1'b1;
        end
    end

    // A new edge beats a same-cycle clear or ovf_clr on the same line
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~clr) | rise;
            ovf_q  <= (ovf_q & ~ovf_clr) | (rise & pend_q & ~clr);
        end
    end

`ifdef IRQ_MASK_EN
    assign pend_out = pend_q & ~irq_mask;
`else
    assign pend_out = pend_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            svc_id_q    <= '0;
            svc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            svc_id_q    <= svc_id_d;
            svc_valid_q <= svc_valid_d;
        end
    end

    // Present one request at a time; no preemption while waiting for ack
    always_comb begin
        state_d     = state_q;
        svc_id_d    = svc_id_q;
        svc_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d     = PRESENT;
                    svc_id_d    = enc_id;
                    svc_valid_d = 1'b1;
                end
            end
            PRESENT: begin
                svc_valid_d = 1'b1;
                if (svc_ack) begin
                    state_d     = IDLE;
                    svc_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign svc_valid = svc_valid_q;
    assign svc_id    = svc_id_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: the bench plays the priority encoder and checks
// every cycle against a rule-level model of pending, overflow and service behaviour.
module tb_irq_request_latch;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] pend_out;
    logic [1:0] enc_id;
    logic       enc_valid;
    logic       svc_valid;
    logic [1:0] svc_id;
    logic       svc_ack;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
    logic [3:0] mask;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    irq_request_latch #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .pend_out  (pend_out),
        .enc_id    (enc_id),
        .enc_valid (enc_valid),
        .svc_valid (svc_valid),
        .svc_id    (svc_id),
        .svc_ack   (svc_ack),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef IRQ_MASK_EN
        ,
        .irq_mask  (mask)
`endif
    );

    // Bench-side 4-to-2 priority encoder, bit 3 highest
    assign enc_valid = |pend_out;
    assign enc_id    = pend_out[3] ? 2'd3 : pend_out[2] ? 2'd2 : pend_out[1] ? 2'd1 : 2'd0;

    function automatic logic [1:0] top_bit(input logic [3:0] v);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Model: past[j] is the request vector sampled j clock edges ago
    logic [3:0] past [1:S+1];
    logic [3:0] m_pend;
    logic [3:0] m_ovf;
    logic       m_busy;
    logic [1:0] m_id;

    always @(posedge clk) begin
        logic [3:0] rise;
        logic [3:0] clrv;
        logic [3:0] elig;
        if (rst) begin
            for (int j = 1; j <= S + 1; j++) past[j] <= 4'b0;
            m_pend <= 4'b0;
            m_ovf  <= 4'b0;
            m_busy <= 1'b0;
            m_id   <= 2'd0;
        end else begin
            rise = past[S] & ~past[S+1];
            clrv = (m_busy && svc_ack) ? (4'b0001 << m_id) : 4'b0000;
            elig = m_pend & ~mask;
            if (m_busy) begin
                if (svc_ack) m_busy <= 1'b0;
            end else if (elig != 4'b0) begin
                m_busy <= 1'b1;
                m_id   <= top_bit(elig);
            end
            m_ovf  <= (m_ovf & ~ovf_clr) | (rise & m_pend & ~clrv);
            m_pend <= (m_pend & ~clrv) | rise;
            for (int j = S + 1; j >= 2; j--) past[j] <= past[j-1];
            past[1] <= req_in;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pend_out", pend_out, m_pend & ~mask);
            chk("model_svc_valid", {3'b0, svc_valid}, {3'b0, m_busy});
            chk("model_svc_id", {2'b0, svc_id}, {2'b0, m_id});
            chk("model_ovf", ovf, m_ovf);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] bits);
        req_in = req_in | bits;
        step();
        req_in = req_in & ~bits;
    endtask

    task automatic wait_svc(input logic [1:0] exp_id);
        int n = 0;
        while (!svc_valid && n < 20) begin
            step();
            n++;
        end
        chk("svc_valid_wait", {3'b0, svc_valid}, 4'b0001);
        chk("svc_id_presented", {2'b0, svc_id}, {2'b0, exp_id});
    endtask

    task automatic ack_it();
        svc_ack = 1'b1;
        step();
        svc_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_in = '0; svc_ack = 1'b0; ovf_clr = '0; mask = '0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_pend_out", pend_out, 4'b0000);
        chk("rst_ovf", ovf, 4'b0000);
        chk("rst_svc_valid", {3'b0, svc_valid}, 4'b0000);
        chk("rst_svc_id", {2'b0, svc_id}, 4'b0000);
        rst = 1'b0;
        step();

        // Single pulse on line 2: pending after 3 edges, presented one later
        pulse(4'b0100);
        step();
        chk("t1_pend_early", pend_out, 4'b0000);
        step();
        chk("t1_pend_set", pend_out, 4'b0100);
        chk("t1_valid_low", {3'b0, svc_valid}, 4'b0000);
        step();
        chk("t1_valid", {3'b0, svc_valid}, 4'b0001);
        chk("t1_id", {2'b0, svc_id}, 4'b0010);
        ack_it();
        chk("t1_pend_clr", pend_out, 4'b0000);
        chk("t1_valid_drop", {3'b0, svc_valid}, 4'b0000);
        step(2);

        // Lines 0 and 3 together: 3 first, a gap cycle, then 0
        pulse(4'b1001);
        wait_svc(2'd3);
        chk("t2_pend_both", pend_out, 4'b1001);
        ack_it();
        chk("t2_gap_valid", {3'b0, svc_valid}, 4'b0000);
        chk("t2_gap_pend", pend_out, 4'b0001);
        step();
        chk("t2_next_valid", {3'b0, svc_valid}, 4'b0001);
        chk("t2_next_id", {2'b0, svc_id}, 4'b0000);
        ack_it();
        step(2);

        // No preemption: line 3 arrives while line 1 is presented
        pulse(4'b0010);
        wait_svc(2'd1);
        pulse(4'b1000);
        step(4);
        chk("t3_hold_id", {2'b0, svc_id}, 4'b0001);
        chk("t3_pend", pend_out, 4'b1010);
        ack_it();
        wait_svc(2'd3);
        ack_it();
        step(2);

        // Overflow on line 2, clear, then edge colliding with ovf_clr
        pulse(4'b0100);
        step(2);
        pulse(4'b0100);
        step(4);
        chk("t4_ovf_set", ovf, 4'b0100);
        ovf_clr = 4'b0100;
        step();
        ovf_clr = 4'b0000;
        chk("t4_ovf_clr", ovf, 4'b0000);
        pulse(4'b0100);
        step();
        ovf_clr = 4'b0100;
        step();
        ovf_clr = 4'b0000;
        chk("t4_set_wins", ovf, 4'b0100);
        chk("t4_id", {2'b0, svc_id}, 4'b0010);
        ack_it();
        chk("t4_pend_clr", pend_out, 4'b0000);
        ovf_clr = 4'b0100;
        step();
        ovf_clr = 4'b0000;
        chk("t4_ovf_final", ovf, 4'b0000);
        step(2);

        // Reset during service, with line 1 held high across release
        pulse(4'b0001);
        wait_svc(2'd0);
        req_in = 4'b0010;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("t5_rst_valid", {3'b0, svc_valid}, 4'b0000);
        chk("t5_rst_pend", pend_out, 4'b0000);
        step(2);
        chk("t5_pend_early", pend_out, 4'b0000);
        step();
        chk("t5_pend_set", pend_out, 4'b0010);
        wait_svc(2'd1);
        ack_it();
        step(6);
        chk("t5_no_rearm", pend_out, 4'b0000);
        chk("t5_idle", {3'b0, svc_valid}, 4'b0000);
        req_in = 4'b0000;
        step(3);

`ifdef IRQ_MASK_EN
        // Masked line latches but is hidden until unmasked
        mask = 4'b1000;
        pulse(4'b1000);
        step(6);
        chk("t6_masked_pend", pend_out, 4'b0000);
        chk("t6_masked_valid", {3'b0, svc_valid}, 4'b0000);
        mask = 4'b0000;
        step();
        chk("t6_unmask_valid", {3'b0, svc_valid}, 4'b0001);
        chk("t6_unmask_id", {2'b0, svc_id}, 4'b0011);
        chk("t6_unmask_pend", pend_out, 4'b1000);
        ack_it();
        step(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
